xc_malu_seq: RTL

- Multi-cycle sequencer for the xc_malu multiply/divide/remainder datapath.
- Accepts one operation at a time from the pipeline over a valid/ready handshake and latches its operands and op select.
- Owns the iteration registers (count, acc, arg_0, arg_1), steps them each cycle from the datapath's next-state outputs, and presents the 64-bit result on a response handshake.
- Sits between the execute stage and the muldivrem datapath instance; both are instantiated by the parent.

---
 rtl/xc_malu_pkg.sv | 37 +++
 rtl/xc_malu_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/xc_malu_pkg.sv
// Shared constants for the xc_malu sequencer: op/pw one-hot indices, FSM encoding,
// and the default watchdog limit.
package xc_malu_pkg;

  localparam int OP_W = 10;
  localparam int PW_W = 5;

  localparam int OP_DIV    = 0;
  localparam int OP_DIVU   = 1;
  localparam int OP_REM    = 2;
  localparam int OP_REMU   = 3;
  localparam int OP_MUL    = 4;
  localparam int OP_MULU   = 5;
  localparam int OP_MULSU  = 6;
  localparam int OP_CLMUL  = 7;
  localparam int OP_PMUL   = 8;
  localparam int OP_PCLMUL = 9;

  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;

  localparam int MAX_CYCLES_DEFAULT = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/xc_malu_seq.sv
// Multi-cycle sequencer for the xc_malu muldivrem datapath: accepts one op, steps the
// iteration registers from the datapath's next-state outputs, and holds the result.
module xc_malu_seq
  import xc_malu_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT,
  parameter int COUNT_W    = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_rs1,
  input  logic [31:0]        req_rs2,
  input  logic [31:0]        req_rs3,
  input  logic [9:0]         req_op,
  input  logic [4:0]         req_pw,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_result,
  output logic               rsp_error,
  output logic               dp_valid,
  output logic               dp_flush,
  output logic [31:0]        dp_rs1,
  output logic [31:0]        dp_rs2,
  output logic [31:0]        dp_rs3,
  output logic [9:0]         dp_op,
  output logic [4:0]         dp_pw,
  output logic [COUNT_W-1:0] dp_count,
  output logic [63:0]        dp_acc,
  output logic [31:0]        dp_arg_0,
  output logic [31:0]        dp_arg_1,
  input  logic [63:0]        dp_n_acc,
  input  logic [31:0]        dp_n_arg_0,
  input  logic [31:0]        dp_n_arg_1,
  input  logic               dp_ready,
  input  logic [63:0]        dp_result,
  output logic [1:0]         dbg_state
);

  // Last count value the watchdog allows in RUN; MAX_CYCLES must stay below 2^COUNT_W.
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(MAX_CYCLES - 1);

  state_e              state, state_n;
  logic [COUNT_W-1:0]  count;
  logic [63:0]         acc;
  logic [31:0]         arg_0, arg_1;
  logic [31:0]         rs1_q, rs2_q, rs3_q;
  logic [OP_W-1:0]     op_q;
  logic [PW_W-1:0]     pw_q;
  logic                accept, op_legal, watchdog;

  // Handshakes: a request transfers on a clock edge where req_valid && req_ready, and a
  // response on one where rsp_valid && rsp_ready. flush withdraws req_ready so a request
  // presented alongside it never transfers.
  assign req_ready = (state == ST_IDLE) && !flush;
  assign rsp_valid = (state == ST_DONE);
  assign dp_valid  = (state == ST_RUN);
  assign dp_flush  = flush | reset;

  assign accept   = req_valid && req_ready;
  assign op_legal = is_onehot(req_op);
  assign watchdog = (count == LAST_COUNT);

  assign dp_rs1    = rs1_q;
  assign dp_rs2    = rs2_q;
  assign dp_rs3    = rs3_q;
  assign dp_op     = op_q;
  assign dp_pw     = pw_q;
  assign dp_count  = count;
  assign dp_acc    = acc;
  assign dp_arg_0  = arg_0;
  assign dp_arg_1  = arg_1;
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = op_legal ? ST_RUN : ST_DONE;
      ST_RUN:  if (dp_ready || watchdog) state_n = ST_DONE;
      ST_DONE: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      acc        <= '0;
      arg_0      <= '0;
      arg_1      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs3_q      <= '0;
      op_q       <= '0;
      pw_q       <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      state <= state_n;
      if (flush) begin
        count     <= '0;
        acc       <= '0;
        arg_0     <= '0;
        arg_1     <= '0;
        rsp_error <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              rs1_q      <= req_rs1;
              rs2_q      <= req_rs2;
              rs3_q      <= req_rs3;
              op_q       <= req_op;
              pw_q       <= req_pw;
              count      <= '0;
              acc        <= '0;
              arg_0      <= '0;
              arg_1      <= '0;
              rsp_result <= '0;
              rsp_error  <= !op_legal;
            end
          end
          ST_RUN: begin
            // A finishing datapath wins over the watchdog; iteration state freezes that cycle.
            if (dp_ready) begin
              rsp_result <= dp_result;
              rsp_error  <= 1'b0;
            end else if (watchdog) begin
              rsp_result <= '0;
              rsp_error  <= 1'b1;
            end else begin
              acc   <= dp_n_acc;
              arg_0 <= dp_n_arg_0;
              arg_1 <= dp_n_arg_1;
              count <= count + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
